// File: rtl/ra_bist_pkg.sv
// Shared types and constants for the register-array March/scan BIST engine.
// Field positions of the ctl/status words live here so every block agrees on them.
package ra_bist_pkg;

  localparam int MAX_ADR_W    = 8;
  localparam int MAX_RD_PORTS = 8;
  localparam int ELEM_W       = 3;

  localparam logic [1:0] ALG_MARCH = 2'b00;
  localparam logic [1:0] ALG_SCAN  = 2'b01;

  localparam int CTL_RUN     = 0;
  localparam int CTL_CLR     = 1;
  localparam int CTL_ALG_LO  = 2;
  localparam int CTL_BG      = 4;
  localparam int CTL_MASK_LO = 16;

  localparam int STS_BUSY     = 0;
  localparam int STS_DONE     = 1;
  localparam int STS_FAIL     = 2;
  localparam int STS_ELEM_LO  = 4;
  localparam int STS_ADR_LO   = 8;
  localparam int STS_PORTS_LO = 16;
  localparam int STS_CNT_LO   = 24;

  localparam logic [ELEM_W-1:0] SCAN_LAST_ELEM = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef enum logic [ELEM_W-1:0] {
    EL_W0      = 3'd0,
    EL_R0W1_UP = 3'd1,
    EL_R1W0_UP = 3'd2,
    EL_R0W1_DN = 3'd3,
    EL_R1W0_DN = 3'd4,
    EL_R0      = 3'd5
  } march_elem_e;

  typedef enum logic {OP_RD, OP_WR} op_kind_e;

  typedef struct packed {
    op_kind_e kind;
    logic     val;
  } op_t;

  // val selects bg (0) or ~bg (1); phase is the second op of a read-write pair
  function automatic op_t op_lookup(input logic scan, input logic [ELEM_W-1:0] elem,
                                    input logic phase);
    op_t op;
    op.kind = OP_RD;
    op.val  = 1'b0;
    if (scan) begin
      op.kind = elem[0] ? OP_RD : OP_WR;
      op.val  = elem[1];
    end else begin
      case (elem)
        EL_W0: op.kind = OP_WR;
        EL_R0: op.kind = OP_RD;
        default: begin
          op.kind = phase ? OP_WR : OP_RD;
          op.val  = phase ? (elem == EL_R0W1_UP || elem == EL_R0W1_DN)
                          : (elem == EL_R1W0_UP || elem == EL_R1W0_DN);
        end
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/ra_bist_cmp.sv
// Latency-matched expected-data pipeline and per-port masked read compare.
// The oldest stage lines up with rd_dat; port 0 occupies the MSBs of rd_dat.
module ra_bist_cmp
  import ra_bist_pkg::*;
#(
  parameter int ADR_W    = 6,
  parameter int DAT_W    = 72,
  parameter int RD_PORTS = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push_vld,
  input  logic [DAT_W-1:0]          push_exp,
  input  logic [ELEM_W-1:0]         push_elem,
  input  logic [ADR_W-1:0]          push_adr,
  input  logic [RD_PORTS*DAT_W-1:0] rd_dat,
  input  logic [RD_PORTS-1:0]       mask,
  output logic [RD_PORTS-1:0]       mis,
  output logic [ELEM_W-1:0]         cmp_elem,
  output logic [ADR_W-1:0]          cmp_adr
);

  logic [RD_LAT-1:0] vld_reg;
  logic [DAT_W-1:0]  exp_reg  [RD_LAT];
  logic [ELEM_W-1:0] elem_reg [RD_LAT];
  logic [ADR_W-1:0]  adr_reg  [RD_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_reg <= '0;
    end else if (flush) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= push_vld;
      for (int i = 1; i < RD_LAT; i++) vld_reg[i] <= vld_reg[i-1];
    end
  end

  // Payload needs no reset: it is only consumed alongside a valid bit.
  always_ff @(posedge clk) begin
    exp_reg[0]  <= push_exp;
    elem_reg[0] <= push_elem;
    adr_reg[0]  <= push_adr;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_reg[i]  <= exp_reg[i-1];
      elem_reg[i] <= elem_reg[i-1];
      adr_reg[i]  <= adr_reg[i-1];
    end
  end

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_port
      assign mis[gi] = vld_reg[RD_LAT-1] && mask[gi] &&
                       (rd_dat[(RD_PORTS-1-gi)*DAT_W +: DAT_W] != exp_reg[RD_LAT-1]);
    end
  endgenerate

  assign cmp_elem = elem_reg[RD_LAT-1];
  assign cmp_adr  = adr_reg[RD_LAT-1];

endmodule

// File: rtl/ra_bist_march_sdr.sv
// SDR BIST engine for NR-read/1-write register arrays: March C- or scan over the
// full address space, muxed in front of the array, with a 32-bit status word.
module ra_bist_march_sdr
  import ra_bist_pkg::*;
#(
  parameter int ADR_W    = 6,
  parameter int DAT_W    = 72,
  parameter int RD_PORTS = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               ctl,
  output logic [31:0]               status,
  input  logic [RD_PORTS-1:0]       rd_enb_in,
  input  logic [RD_PORTS*ADR_W-1:0] rd_adr_in,
  input  logic [RD_PORTS*DAT_W-1:0] rd_dat,
  input  logic                      wr_enb_in,
  input  logic [ADR_W-1:0]          wr_adr_in,
  input  logic [DAT_W-1:0]          wr_dat_in,
  output logic [RD_PORTS-1:0]       rd_enb_out,
  output logic [RD_PORTS*ADR_W-1:0] rd_adr_out,
  output logic                      wr_enb_out,
  output logic [ADR_W-1:0]          wr_adr_out,
  output logic [DAT_W-1:0]          wr_dat_out
);

  localparam logic [ADR_W-1:0] ADR_MAX = '1;

  state_e                  state_reg, state_next;
  logic [ELEM_W-1:0]       elem_reg, elem_next, elem_inc;
  logic [ADR_W-1:0]        adr_reg, adr_next;
  logic                    phase_reg, phase_next;
  logic [2:0]              drain_reg, drain_next;
  logic                    run_d_reg, scan_reg, bg_reg;
  logic                    busy, start, abort, clr, drain_end;
  logic                    two_phase, down, next_down, last_elem, at_end;
  op_t                     op;
  logic                    bist_rd, bist_wr;
  logic [DAT_W-1:0]        bist_dat;
  logic [RD_PORTS-1:0]     mis;
  logic [ELEM_W-1:0]       cmp_elem;
  logic [ADR_W-1:0]        cmp_adr;
  logic                    done_reg, fail_reg;
  logic [ELEM_W-1:0]       ff_elem_reg;
  logic [MAX_ADR_W-1:0]    ff_adr_reg;
  logic [MAX_RD_PORTS-1:0] fail_ports_reg;
  logic [7:0]              fail_cnt_reg;
  logic                    unused_ctl;

  assign busy       = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign start      = !busy && ctl[CTL_RUN] && !run_d_reg;
  assign abort      = busy && !ctl[CTL_RUN];
  assign clr        = !busy && ctl[CTL_CLR];
  assign unused_ctl = ^{ctl[31:24], ctl[23:16], ctl[15:5]};

  assign op        = op_lookup(scan_reg, elem_reg, phase_reg);
  assign two_phase = !scan_reg && (elem_reg != EL_W0) && (elem_reg != EL_R0);
  assign down      = !scan_reg && (elem_reg == EL_R0W1_DN || elem_reg == EL_R1W0_DN);
  assign elem_inc  = elem_reg + 1'b1;
  assign next_down = !scan_reg && (elem_inc == EL_R0W1_DN || elem_inc == EL_R1W0_DN);
  assign last_elem = scan_reg ? (elem_reg == SCAN_LAST_ELEM) : (elem_reg == EL_R0);
  assign at_end    = down ? (adr_reg == '0) : (adr_reg == ADR_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      elem_reg  <= '0;
      adr_reg   <= '0;
      phase_reg <= 1'b0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
      adr_reg   <= adr_next;
      phase_reg <= phase_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    elem_next  = elem_reg;
    adr_next   = adr_reg;
    phase_next = phase_reg;
    drain_next = drain_reg;
    drain_end  = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          elem_next  = '0;
          adr_next   = '0;
          phase_next = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (two_phase && !phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (!at_end) begin
            adr_next = down ? adr_reg - 1'b1 : adr_reg + 1'b1;
          end else if (last_elem) begin
            state_next = S_DRAIN;
            drain_next = '0;
          end else begin
            elem_next = elem_inc;
            adr_next  = next_down ? ADR_MAX : '0;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (drain_reg == 3'(RD_LAT - 1)) begin
          state_next = S_DONE;
          drain_end  = 1'b1;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_d_reg      <= 1'b0;
      scan_reg       <= 1'b0;
      bg_reg         <= 1'b0;
      done_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      ff_elem_reg    <= '0;
      ff_adr_reg     <= '0;
      fail_ports_reg <= '0;
      fail_cnt_reg   <= '0;
    end else begin
      run_d_reg <= ctl[CTL_RUN];
      if (start || clr) begin
        done_reg       <= 1'b0;
        fail_reg       <= 1'b0;
        ff_elem_reg    <= '0;
        ff_adr_reg     <= '0;
        fail_ports_reg <= '0;
        fail_cnt_reg   <= '0;
      end
      if (start) begin
        scan_reg <= (ctl[CTL_ALG_LO +: 2] == ALG_SCAN);
        bg_reg   <= ctl[CTL_BG];
      end
      // An abort edge drops whatever compare result is still in flight.
      if (busy && !abort) begin
        if (|mis) begin
          fail_reg       <= 1'b1;
          fail_ports_reg <= fail_ports_reg | MAX_RD_PORTS'(mis);
          if (fail_cnt_reg != 8'hFF) fail_cnt_reg <= fail_cnt_reg + 1'b1;
          if (!fail_reg) begin
            ff_elem_reg <= cmp_elem;
            ff_adr_reg  <= MAX_ADR_W'(cmp_adr);
          end
        end
        if (drain_end) done_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    status                            = '0;
    status[STS_BUSY]                  = busy;
    status[STS_DONE]                  = done_reg;
    status[STS_FAIL]                  = fail_reg;
    status[STS_ELEM_LO +: ELEM_W]     = ff_elem_reg;
    status[STS_ADR_LO +: MAX_ADR_W]   = ff_adr_reg;
    status[STS_PORTS_LO +: MAX_RD_PORTS] = fail_ports_reg;
    status[STS_CNT_LO +: 8]           = fail_cnt_reg;
  end

  assign bist_rd  = (state_reg == S_RUN) && (op.kind == OP_RD);
  assign bist_wr  = (state_reg == S_RUN) && (op.kind == OP_WR);
  assign bist_dat = {DAT_W{bg_reg & adr_reg[0]}} ^ {DAT_W{op.val}};

  assign rd_enb_out = busy ? {RD_PORTS{bist_rd}} : rd_enb_in;
  assign rd_adr_out = busy ? {RD_PORTS{adr_reg}} : rd_adr_in;
  assign wr_enb_out = busy ? bist_wr : wr_enb_in;
  assign wr_adr_out = busy ? adr_reg : wr_adr_in;
  assign wr_dat_out = busy ? bist_dat : wr_dat_in;

  ra_bist_cmp #(
    .ADR_W   (ADR_W),
    .DAT_W   (DAT_W),
    .RD_PORTS(RD_PORTS),
    .RD_LAT  (RD_LAT)
  ) u_cmp (
    .clk      (clk),
    .reset    (reset),
    .flush    (abort),
    .push_vld (bist_rd),
    .push_exp (bist_dat),
    .push_elem(elem_reg),
    .push_adr (adr_reg),
    .rd_dat   (rd_dat),
    .mask     (ctl[CTL_MASK_LO +: RD_PORTS]),
    .mis      (mis),
    .cmp_elem (cmp_elem),
    .cmp_adr  (cmp_adr)
  );

endmodule
